// File: rtl/change_dispenser.sv
// change_dispenser: breaks a rupee amount into coins (100/50/20/10/5, largest first).
// Coins are requested one at a time from a coin mechanism by a valid/ack handshake.
// Optional per-denomination inventory is enabled by defining COIN_INVENTORY_EN.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   change_valid_i/change_amt_i   amount offer (accepted in IDLE while change_ready_o=1)
//   change_ready_o                block idle and able to accept an amount
//   coin_valid_o/coin_denom_o     eject request and coin code (1=5,2=10,3=20,4=50,5=100)
//   coin_ack_i                    coin ejected
//   done_o, residue_o, short_o    end-of-dispense pulse, undispensed amount, inventory shortfall
//   coin_count_o                  coins ejected for the current amount
//   jam_o, clear_i                missing-ack fault and its clear
//   refill_i/refill_denom_i       add one coin of the given code to inventory
module change_dispenser #(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned INV_INIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change_valid_i,
  input  logic [8:0] change_amt_i,
  output logic       change_ready_o,
  output logic       coin_valid_o,
  output logic [2:0] coin_denom_o,
  input  logic       coin_ack_i,
  output logic       done_o,
  output logic [8:0] residue_o,
  output logic [6:0] coin_count_o,
  output logic       jam_o,
  input  logic       clear_i,
  output logic       short_o,
  input  logic       refill_i,
  input  logic [2:0] refill_denom_i
);

  localparam int unsigned AMT_W   = 9;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned N_DENOM = 5;
  localparam int unsigned TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [AMT_W-1:0]    remaining;
  logic [CODE_W-1:0]   denom_r;
  logic [TMR_W-1:0]    tmr;
  logic [CODE_W-1:0]   sel_code;
  logic [N_DENOM-1:0]  usable;
  logic                accept_c;
  logic                ack_c;
  logic                short_c;

  // Rupee value of a coin code; code 0 has no value.
  function automatic logic [AMT_W-1:0] denom_value(input logic [CODE_W-1:0] code);
    case (code)
      3'd1:    denom_value = 9'd5;
      3'd2:    denom_value = 9'd10;
      3'd3:    denom_value = 9'd20;
      3'd4:    denom_value = 9'd50;
      3'd5:    denom_value = 9'd100;
      default: denom_value = 9'd0;
    endcase
  endfunction

`ifdef COIN_INVENTORY_EN
  logic [7:0] inv [N_DENOM];

  // Inventory counters: ack consumes, refill adds (saturating); both at once cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_DENOM; i++) inv[i] <= 8'(INV_INIT);
    end else begin
      for (int i = 0; i < N_DENOM; i++) begin
        if (refill_i && refill_denom_i == CODE_W'(i + 1) &&
            !(ack_c && denom_r == CODE_W'(i + 1))) begin
          if (inv[i] != 8'd255) inv[i] <= inv[i] + 8'd1;
        end else if (ack_c && denom_r == CODE_W'(i + 1) &&
                     !(refill_i && refill_denom_i == CODE_W'(i + 1))) begin
          inv[i] <= inv[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    usable = '0;
    for (int i = 0; i < N_DENOM; i++) usable[i] = (inv[i] != 8'd0);
  end

  assign short_c = (remaining >= 9'd5);
`else
  logic unused_refill;
  assign unused_refill = ^{refill_i, refill_denom_i};
  assign usable  = '1;
  assign short_c = 1'b0;
`endif

  // Largest usable coin not exceeding the remaining amount (0 when none fits).
  always_comb begin
    sel_code = '0;
    for (int c = 1; c <= N_DENOM; c++) begin
      if (usable[c-1] && denom_value(CODE_W'(c)) <= remaining) sel_code = CODE_W'(c);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; an ack is only taken while the request is visible, and beats the timeout.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    ack_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (change_valid_i && change_ready_o) begin
          accept_c   = 1'b1;
          next_state = S_SELECT;
        end
      end
      S_SELECT: next_state = (sel_code == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (coin_valid_o) begin
          if (coin_ack_i) begin
            ack_c      = 1'b1;
            next_state = S_SELECT;
          end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
            next_state = S_FAULT;
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      S_FAULT: if (clear_i) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: remaining amount, chosen coin, ack timer (zero outside ISSUE).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      denom_r   <= '0;
      tmr       <= '0;
    end else begin
      if (accept_c)                       remaining <= change_amt_i;
      else if (ack_c)                     remaining <= remaining - denom_value(denom_r);
      else if (state == S_FAULT && clear_i) remaining <= '0;

      if (state == S_SELECT) denom_r <= sel_code;

      if (state != S_ISSUE)                 tmr <= '0;
      else if (coin_valid_o && !coin_ack_i) tmr <= tmr + TMR_W'(1);
    end
  end

  // Registered outputs; the coin request appears one cycle into ISSUE and drops on ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      change_ready_o <= 1'b0;
      coin_valid_o   <= 1'b0;
      coin_denom_o   <= '0;
      done_o         <= 1'b0;
      residue_o      <= '0;
      coin_count_o   <= '0;
      jam_o          <= 1'b0;
      short_o        <= 1'b0;
    end else begin
      change_ready_o <= (next_state == S_IDLE);
      coin_valid_o   <= (state == S_ISSUE) && (next_state == S_ISSUE);
      coin_denom_o   <= ((state == S_ISSUE) && (next_state == S_ISSUE)) ? denom_r : '0;
      done_o         <= (state == S_DONE);
      jam_o          <= (next_state == S_FAULT);
      if (accept_c) begin
        residue_o    <= '0;
        coin_count_o <= '0;
        short_o      <= 1'b0;
      end else begin
        if (ack_c) coin_count_o <= coin_count_o + CNT_W'(1);
        if (state == S_DONE) begin
          residue_o <= remaining;
          short_o   <= short_c;
        end
      end
    end
  end

endmodule
